led_pattern_gen: RTL



---
 rtl/led_pkg.sv | 13 +
 rtl/led_channel.sv | 90 +++++++++
 rtl/led_pattern_gen.sv | 79 +++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types for the multi-channel LED pattern generator.
package led_pkg;

  localparam int LED_MODE_W = 2;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_OFF,
    LED_ON,
    LED_BLINK,
    LED_BREATHE
  } led_mode_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/duty/pattern state and drives a registered LED bit
// from the shared tick and PWM counter.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 load,
  input  led_mode_t            mode,
  input  logic [PWM_WIDTH-1:0] duty,
  input  led_mode_t            reset_mode,
  output logic                 led
);

  localparam logic [PWM_WIDTH-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_WIDTH-1:0] LEVEL_ONE = PWM_WIDTH'(1);

  led_mode_t            r_mode;
  logic [PWM_WIDTH-1:0] r_duty;
  logic [PWM_WIDTH-1:0] r_ramp;
  logic                 r_phase;
  logic                 r_dirDown;
  logic                 r_led;

  logic [PWM_WIDTH-1:0] w_rampNext;
  logic                 w_dirDownNext;
  logic                 w_ledNext;

  // The direction flips on arrival at an endpoint so each endpoint is held one tick.
  always_comb begin
    w_rampNext    = r_dirDown ? (r_ramp - LEVEL_ONE) : (r_ramp + LEVEL_ONE);
    w_dirDownNext = r_dirDown;
    if (w_rampNext == LEVEL_MAX) begin
      w_dirDownNext = 1'b1;
    end else if (w_rampNext == '0) begin
      w_dirDownNext = 1'b0;
    end
  end

  // A config load takes priority over a coincident tick and restarts the pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode    <= reset_mode;
      r_duty    <= '0;
      r_phase   <= 1'b0;
      r_ramp    <= '0;
      r_dirDown <= 1'b0;
    end else if (load) begin
      r_mode    <= mode;
      r_duty    <= duty;
      r_phase   <= 1'b0;
      r_ramp    <= '0;
      r_dirDown <= 1'b0;
    end else if (tick) begin
      if (r_mode == LED_BLINK) begin
        r_phase <= ~r_phase;
      end
      if (r_mode == LED_BREATHE) begin
        r_ramp    <= w_rampNext;
        r_dirDown <= w_dirDownNext;
      end
    end
  end

  always_comb begin
    w_ledNext = 1'b0;
    case (r_mode)
      LED_OFF:     w_ledNext = 1'b0;
      LED_ON:      w_ledNext = (r_duty == LEVEL_MAX) ? 1'b1 : (pwm_cnt < r_duty);
      LED_BLINK:   w_ledNext = r_phase;
      LED_BREATHE: w_ledNext = (pwm_cnt < r_ramp);
      default:     w_ledNext = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= w_ledNext;
    end
  end

  assign led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter, config write decode,
// and one led_channel per output.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int  CHANNELS        = 4,
  parameter int  PRESCALE_DIV    = 6_000_000,
  parameter int  PWM_WIDTH       = 8,
  parameter int  RESET_BLINK_CH0 = 1,
  localparam int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [LED_MODE_W-1:0] cfg_mode,
  input  logic [PWM_WIDTH-1:0]  cfg_duty,
  output logic [CHANNELS-1:0]   led,
  output logic                  tick
);

  localparam int             PS_W    = $clog2(PRESCALE_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0]      r_prescale;
  logic                 r_tick;
  logic [PWM_WIDTH-1:0] r_pwmCnt;

  logic [CHANNELS-1:0]  w_load;
  led_mode_t            w_cfgMode;
  logic                 w_prescaleWrap;

  assign w_prescaleWrap = (r_prescale == PS_LAST);
  assign w_cfgMode      = led_mode_t'(cfg_mode);

  // The tick goes high in the cycle after the prescaler sits on its last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_prescale <= w_prescaleWrap ? '0 : (r_prescale + PS_W'(1));
      r_tick     <= w_prescaleWrap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwmCnt <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + PWM_WIDTH'(1);
    end
  end

  assign tick = r_tick;

  // Out-of-range channel numbers match no decode term and are silently dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
    localparam led_mode_t RESET_MODE =
      ((g == 0) && (RESET_BLINK_CH0 != 0)) ? LED_BLINK : LED_OFF;

    assign w_load[g] = cfg_we && (cfg_ch == CH_W'(g));

    led_channel #(
      .PWM_WIDTH (PWM_WIDTH)
    ) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (r_tick),
      .pwm_cnt    (r_pwmCnt),
      .load       (w_load[g]),
      .mode       (w_cfgMode),
      .duty       (cfg_duty),
      .reset_mode (RESET_MODE),
      .led        (led[g])
    );
  end

endmodule
